// File: rtl/cdu_pkg.sv
// Shared types and default sizing for the CDU error-counter controller.
package cdu_pkg;
  typedef enum logic [1:0] {DISABLED, SETTLE, ACTIVE, ZERO} ec_state_t;

  // The count width must hold +/-EC_LIMIT in two's complement.
  localparam int EC_CNT_W       = 10;
  localparam int EC_LIMIT       = 384;
  localparam int EC_SYNC_STAGES = 2;
  localparam int EC_SETTLE_CYC  = 16;
endpackage

// File: rtl/cdu_sync_edge.sv
// N-stage synchroniser with a registered rising-edge detector; all flops reset-clearable.
module cdu_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // prev_q resets high so a level already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= 1'b1;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign level = sync_q[STAGES-1];
endmodule

// File: rtl/cdu_error_counter_ctrl.sv
// CDU error-counter sequencer: AGC moding FSM, saturating signed count, DAC update strobe.
// Optional dropped-pulse tally enabled by defining CDU_EC_DROP_COUNT_EN.
module cdu_error_counter_ctrl
  import cdu_pkg::*;
#(
  parameter int CNT_W       = EC_CNT_W,
  parameter int CNT_LIMIT   = EC_LIMIT,
  parameter int SYNC_STAGES = EC_SYNC_STAGES,
  parameter int SETTLE_CYC  = EC_SETTLE_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    AGCEEC_n,
  input  logic                    AGCZ_n,
  input  logic                    AFpPCH,
  input  logic                    AFmPCH,
  output logic signed [CNT_W-1:0] dac_code,
  output logic                    dac_upd,
  output logic                    ec_active,
  output logic                    ec_sat
`ifdef CDU_EC_DROP_COUNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);
  localparam int TMR_W = $clog2(SETTLE_CYC + 1);
  localparam logic signed [CNT_W-1:0] POS_LIM = CNT_W'(CNT_LIMIT);
  localparam logic signed [CNT_W-1:0] NEG_LIM = CNT_W'(-CNT_LIMIT);
  localparam logic signed [CNT_W-1:0] ONE     = CNT_W'(1);

  function automatic logic signed [CNT_W-1:0] sat_step(input logic signed [CNT_W-1:0] c,
                                                       input logic up, input logic dn);
    if (up && !dn && c != POS_LIM) return c + ONE;
    if (dn && !up && c != NEG_LIM) return c - ONE;
    return c;
  endfunction

  function automatic logic at_limit(input logic signed [CNT_W-1:0] c);
    return (c == POS_LIM) || (c == NEG_LIM);
  endfunction

  ec_state_t               state;
  logic [TMR_W-1:0]        tmr;
  logic                    een_lvl, z_lvl, p_lvl, m_lvl;
  logic                    een_rise, z_rise, p_rise, m_rise;
  logic                    unused_sync;
  logic signed [CNT_W-1:0] cnt_step;

  cdu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_p (
    .clk(clk), .rst(rst), .din(AFpPCH), .level(p_lvl), .rise(p_rise));
  cdu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_m (
    .clk(clk), .rst(rst), .din(AFmPCH), .level(m_lvl), .rise(m_rise));
  // Active-low moding inputs reset to their inactive level.
  cdu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_een (
    .clk(clk), .rst(rst), .din(AGCEEC_n), .level(een_lvl), .rise(een_rise));
  cdu_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_z (
    .clk(clk), .rst(rst), .din(AGCZ_n), .level(z_lvl), .rise(z_rise));

  assign unused_sync = p_lvl ^ m_lvl ^ een_rise ^ z_rise;
  assign cnt_step    = sat_step(dac_code, p_rise, m_rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISABLED;
      tmr       <= '0;
      dac_code  <= '0;
      dac_upd   <= 1'b0;
      ec_active <= 1'b0;
      ec_sat    <= 1'b0;
    end else begin
      dac_upd   <= 1'b0;
      ec_active <= 1'b0;
      if (!z_lvl) begin
        state    <= ZERO;
        dac_code <= '0;
        ec_sat   <= 1'b0;
        dac_upd  <= (dac_code != '0);
      end else if (state == ZERO) begin
        state <= een_lvl ? DISABLED : SETTLE;
        tmr   <= '0;
      end else if (een_lvl) begin
        state    <= DISABLED;
        dac_code <= '0;
        ec_sat   <= 1'b0;
        dac_upd  <= (dac_code != '0);
      end else begin
        case (state)
          DISABLED: begin
            state <= SETTLE;
            tmr   <= '0;
          end
          SETTLE: begin
            if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
              state     <= ACTIVE;
              ec_active <= 1'b1;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: begin
            ec_active <= 1'b1;
            dac_code  <= cnt_step;
            dac_upd   <= (cnt_step != dac_code);
            ec_sat    <= at_limit(cnt_step);
          end
        endcase
      end
    end
  end

`ifdef CDU_EC_DROP_COUNT_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    if (a > 16'hFFFF - {14'b0, b}) return 16'hFFFF;
    return a + {14'b0, b};
  endfunction

  logic       run;
  logic [1:0] drop_inc;

  // A lone edge that leaves the count unchanged in ACTIVE is a saturation drop.
  always_comb begin
    run      = z_lvl && !een_lvl && (state != ZERO);
    drop_inc = 2'd0;
    if (run && state == SETTLE)
      drop_inc = {1'b0, p_rise} + {1'b0, m_rise};
    else if (run && state == ACTIVE && (p_rise ^ m_rise) && (cnt_step == dac_code))
      drop_inc = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else     drop_count <= sat_add16(drop_count, drop_inc);
  end
`endif
endmodule

// File: tb/tb_cdu_error_counter_ctrl.sv
// Randomized self-checking bench for cdu_error_counter_ctrl with a transaction-level model.
module tb_cdu_error_counter_ctrl;
  import cdu_pkg::*;
  localparam int W   = EC_CNT_W;
  localparam int LIM = EC_LIMIT;
  localparam int SS  = EC_SYNC_STAGES;
  localparam int SC  = EC_SETTLE_CYC;

  logic clk = 1'b0, rst = 1'b1;
  logic AGCEEC_n = 1'b1, AGCZ_n = 1'b1, AFpPCH = 1'b0, AFmPCH = 1'b0;
  logic signed [W-1:0] dac_code;
  logic dac_upd, ec_active, ec_sat;
`ifdef CDU_EC_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  cdu_error_counter_ctrl dut (
    .clk(clk), .rst(rst), .AGCEEC_n(AGCEEC_n), .AGCZ_n(AGCZ_n),
    .AFpPCH(AFpPCH), .AFmPCH(AFmPCH), .dac_code(dac_code), .dac_upd(dac_upd),
    .ec_active(ec_active), .ec_sat(ec_sat)
`ifdef CDU_EC_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  int n_chk = 0, n_bad = 0;
  int upd_seen = 0, upd_base = 0;
  // model: mode 0=off 1=settling 2=counting 3=held at zero
  int m_cnt = 0, m_drop = 0, m_upd = 0, m_mode = 0;
  bit m_en = 0;

  always @(negedge clk) if (!rst && dac_upd) upd_seen++;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_edge(input bit p, input bit m);
    if (m_mode == 2) begin
      if (p && !m) begin
        if (m_cnt == LIM) m_drop++;
        else begin m_cnt++; m_upd++; end
      end else if (m && !p) begin
        if (m_cnt == -LIM) m_drop++;
        else begin m_cnt--; m_upd++; end
      end
    end else if (m_mode == 1) begin
      m_drop += int'(p) + int'(m);
    end
    if (m_drop > 65535) m_drop = 65535;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".code"}, dac_code, m_cnt);
    chk({tag, ".upd"}, upd_seen - upd_base, m_upd);
    chk({tag, ".sat"}, ec_sat, (m_cnt == LIM || m_cnt == -LIM) ? 1 : 0);
    chk({tag, ".act"}, ec_active, (m_mode == 2) ? 1 : 0);
`ifdef CDU_EC_DROP_COUNT_EN
    chk({tag, ".drop"}, drop_count, m_drop);
`endif
    upd_base = upd_seen;
    m_upd    = 0;
  endtask

  task automatic fast(input bit p, input bit m);
    AFpPCH = p; AFmPCH = m;
    cyc(2);
    AFpPCH = 1'b0; AFmPCH = 1'b0;
    cyc(3);
  endtask

  task automatic burst(input int n, input bit p, input bit m);
    repeat (n) begin fast(p, m); m_edge(p, m); end
  endtask

  task automatic pulse_chk(input bit p, input bit m);
    bit chg;
    int lat, w;
    chg = (m_mode == 2) && (p != m) && !(p && m_cnt == LIM) && !(m && m_cnt == -LIM);
    lat = 0;
    w   = $urandom_range(2, 5);
    AFpPCH = p; AFmPCH = m;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == w) begin AFpPCH = 1'b0; AFmPCH = 1'b0; end
      if (dac_upd && lat == 0) lat = i;
    end
    cyc(3);
    chk("latency", lat, chg ? SS + 2 : 0);
    m_edge(p, m);
    check_all("pulse");
  endtask

  task automatic enable_op(input bit settle_pulse, input bit pm);
    int k;
    AGCEEC_n = 1'b0; m_en = 1; m_mode = 1;
    if (settle_pulse) begin
      k = $urandom_range(1, 8);
      cyc(k);
      fast(pm, !pm);
      m_edge(pm, !pm);
    end
    cyc(SC + 8);
    m_mode = 2;
    check_all("enable");
  endtask

  task automatic disable_op();
    AGCEEC_n = 1'b1; m_en = 0;
    cyc(6);
    if (m_cnt != 0) m_upd++;
    m_cnt = 0; m_mode = 0;
    check_all("disable");
  endtask

  task automatic zero_op();
    bit p;
    AGCZ_n = 1'b0;
    cyc(5);
    if (m_cnt != 0) m_upd++;
    m_cnt = 0; m_mode = 3;
    check_all("zero");
    p = 1'($urandom_range(0, 1));
    fast(p, !p);
    m_edge(p, !p);
    cyc(4);
    check_all("zero_ign");
    AGCZ_n = 1'b1;
    cyc(4);
    chk("zero_rel.act", ec_active, 0);
    cyc(SC + 4);
    m_mode = m_en ? 2 : 0;
    check_all("zero_exit");
  endtask

  task automatic rst_mid();
    AFpPCH = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    chk("rst.code", dac_code, 0);
    chk("rst.upd", dac_upd, 0);
    chk("rst.act", ec_active, 0);
    chk("rst.sat", ec_sat, 0);
    m_cnt = 0; m_drop = 0; m_upd = 0; m_mode = 1;
    rst = 1'b0;
    upd_base = upd_seen;
    cyc(8);
    chk("rst_hold.code", dac_code, 0);
    AFpPCH = 1'b0;
    cyc(SC + 6);
    m_mode = m_en ? 2 : 0;
    check_all("post_rst");
    pulse_chk(1, 0);
  endtask

  initial begin
    int r, n;
    cyc(3);
    chk("reset.code", dac_code, 0);
    chk("reset.upd", dac_upd, 0);
    chk("reset.act", ec_active, 0);
    chk("reset.sat", ec_sat, 0);
`ifdef CDU_EC_DROP_COUNT_EN
    chk("reset.drop", drop_count, 0);
`endif
    rst = 1'b0;
    cyc(4);
    check_all("idle");

    enable_op(1'b0, 1'b0);
    repeat (5) pulse_chk(1, 0);
    burst(390, 1, 0);
    check_all("sat_pos");
    pulse_chk(1, 0);
    pulse_chk(0, 1);

    disable_op();
    enable_op(1'b0, 1'b0);
    burst(10, 1, 0);
    pulse_chk(1, 1);
    burst(27, 1, 0);
    check_all("at37");
    zero_op();

    burst(20, 0, 1);
    check_all("neg20");
    disable_op();
    enable_op(1'b1, 1'($urandom_range(0, 1)));
    burst(390, 0, 1);
    check_all("sat_neg");
    pulse_chk(0, 1);
    pulse_chk(1, 0);

    rst_mid();

    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        n = $urandom_range(0, 2);
        pulse_chk(n != 1, n != 0);
      end else if (r == 6) begin
        n = $urandom_range(1, 20);
        burst(n, r[0], !r[0]);
        check_all("burst");
      end else if (r == 7) begin
        zero_op();
      end else begin
        disable_op();
        enable_op(1'b1, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
